// File: rtl/cmp_sweep_ctrl.sv
// cmp_sweep_ctrl: sweeps all 16 (a,b) pairs into the comparator, counts colors and builds a signature
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       begin a sweep (accepted only when idle)
//   abort                       end a running sweep early (honoured only while driving)
//   red_in, blue_in, green_in   comparator color outputs
//   a_out, b_out                operands driven to the comparator
//   busy                        high while pairs are being driven
//   done                        one-cycle pulse when a full sweep completes
//   aborted                     sticky flag set by abort, cleared by the next accepted start
//   red_cnt, blue_cnt, green_cnt  pairs that lit each color
//   sig                         8-bit signature folded from every sample
module cmp_sweep_ctrl #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       red_in,
    input  logic       blue_in,
    input  logic       green_in,
    output logic [1:0] a_out,
    output logic [1:0] b_out,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [4:0] red_cnt,
    output logic [4:0] blue_cnt,
    output logic [4:0] green_cnt,
    output logic [7:0] sig
);
    typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
    state_t state;
    logic [3:0] idx;
    logic [7:0] dwell;
    logic [3:0] nxt;
    logic       last;
    assign nxt  = idx + 4'd1;
    assign last = dwell == 8'(DWELL - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            dwell     <= '0;
            a_out     <= '0;
            b_out     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            red_cnt   <= '0;
            blue_cnt  <= '0;
            green_cnt <= '0;
            sig       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        state     <= DRIVE;
                        busy      <= 1'b1;
                        idx       <= '0;
                        dwell     <= '0;
                        a_out     <= '0;
                        b_out     <= '0;
                        aborted   <= 1'b0;
                        red_cnt   <= '0;
                        blue_cnt  <= '0;
                        green_cnt <= '0;
                        sig       <= '0;
                    end
                end
                DRIVE: begin
                    if (abort) begin
                        // abort wins over a coincident sample, which is dropped
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (last) begin
                        red_cnt   <= red_cnt + 5'(red_in);
                        blue_cnt  <= blue_cnt + 5'(blue_in);
                        green_cnt <= green_cnt + 5'(green_in);
                        sig <= {sig[6:0], sig[7] ^ sig[5] ^ sig[4] ^ sig[3]} ^ {5'b0, red_in, blue_in, green_in};
                        if (idx == 4'd15) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= nxt;
                            dwell <= '0;
                            a_out <= nxt[3:2];
                            b_out <= nxt[1:0];
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/cmp_sweep_ctrl.md
# cmp_sweep_ctrl

Sweep controller for the 2-bit comparator/RGB LED block. On a start request it drives every one of the 16 (a, b) operand pairs into the comparator in order and holds each pair for a programmable settle time. After each settle time it samples the comparator's red/blue/green outputs, counts the pairs that light each color, and folds every sample into an 8-bit signature. The block sits between the board-level control (button/switch) and the comparator instance, and serves as the on-board self-test for that datapath.

## Interface
- DWELL, 4, cycles each operand pair is held before sampling; legal range 1..255.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate a running sweep; sampled only in DRIVE.
- red_in, blue_in, green_in  input  1 each  comparator color outputs.
- a_out  output  2  operand a to comparator.
- b_out  output  2  operand b to comparator.
- busy  output  1  high while in DRIVE.
- done  output  1  one-cycle pulse on sweep completion.
- aborted  output  1  sticky; set by abort, cleared by next accepted start.
- red_cnt, blue_cnt, green_cnt  output  5 each  pairs sampled with that color high (0..16).
- sig  output  8  sample signature.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE: busy=0, done=0, a_out/b_out hold their last values. If start=1, go to DRIVE and clear idx (4 bits), dwell counter, all three counts, sig, and aborted.
- DRIVE: a_out=idx[3:2], b_out=idx[1:0]; the dwell counter counts 0..DWELL-1.
  - On the cycle where dwell==DWELL-1 (the sample cycle), the block registers the colors:
    - Each count increments by its color bit.
    - sig_next = {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} XOR {5'b0, red_in, blue_in, green_in}.
  - After a sample with idx<15: idx increments and dwell returns to 0.
  - After the sample with idx=15: go to DONE. idx does not wrap and a_out/b_out stay at 3/3.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Results (counts, sig) hold until the next accepted start.
- abort=1 in DRIVE: go to IDLE next cycle and set aborted=1. done does not pulse. Counts and sig keep their partial values. If abort coincides with a sample cycle, the sample is discarded.
- start is ignored outside IDLE; start in DONE is also ignored.
- abort is ignored outside DRIVE.
- Counts cannot overflow: there are at most 16 samples and the counts are 5 bits wide.

## Timing
- Reset (rst=1 at an edge): state=IDLE, a_out=0, b_out=0, busy=0, done=0, aborted=0, all counts=0, sig=0x00. Reset mid-sweep takes priority over everything else.
- start accepted at edge k:
  - busy=1 and a_out=b_out=0 from cycle k+1.
  - Pair n is driven during cycles k+1+n·DWELL through k+(n+1)·DWELL; its colors are sampled at the last of those cycles.
  - Final sample is at edge k+16·DWELL. The count/sig update is visible in the following cycle.
  - done=1 during cycle k+16·DWELL+1. busy falls in that same cycle.
  - Earliest next start is accepted at edge k+16·DWELL+2.
- Comparator path is combinational. With DWELL=1 the sample is taken in the same cycle the pair is driven. Total sweep is 16·DWELL+1 cycles, start edge to done pulse.

## Test plan
- Reset: drive rst=1 during a sweep at pair 5 -> next cycle shows all outputs 0, state IDLE. A later start sweeps from pair 0.
- Colors tied 0, DWELL=4, start -> busy high for 64 cycles; done pulses once at cycle 65; counts=0, sig=0x00.
- Colors tied 1, DWELL=1 -> red_cnt=blue_cnt=green_cnt=16; done at cycle 17. Check a_out/b_out step (0,0),(0,1)…(3,3), one pair per cycle.
- green_in=1 only while a_out=3 and b_out=2 (idx 14), others 0 -> green_cnt=1, others 0; sig=0x02. The same stimulus gated to idx 15 instead -> sig=0x01.
- Behavioral comparator model connected, DWELL=3 -> counts and sig match the model's sequence. start pulses during busy and during DONE are ignored: exactly one done pulse.
- abort on the sample cycle of pair 7 with colors tied 1 -> IDLE next cycle, aborted=1, no done pulse, counts=7. A subsequent start clears aborted and the counts.
